// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ids, field widths, one-hot port codes and the
// input-buffer FSM state type.
package noc_pkg;

  localparam int FLIT_ID_W = 3;
  localparam int LEN_W     = 12;

  localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

  // One-hot arbiter state codes; each input port owns one bit.
  localparam logic [5:0] PORT_IDLE = 6'b000001;
  localparam logic [5:0] PORT_L    = 6'b000010;
  localparam logic [5:0] PORT_N    = 6'b000100;
  localparam logic [5:0] PORT_E    = 6'b001000;
  localparam logic [5:0] PORT_W    = 6'b010000;
  localparam logic [5:0] PORT_S    = 6'b100000;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} ibuf_state_t;

  function automatic logic flit_id_legal(input logic [FLIT_ID_W-1:0] id);
    return (id == FLIT_HEADER) || (id == FLIT_BODY) || (id == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Generic synchronous FIFO: registered pointers and fill, head shown
// combinationally, no write-to-read bypass. Push/pop are gated by full/empty.
module flit_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (fill == (AW + 1)'(DEPTH));
  assign empty   = (fill == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/input_port_buffer.sv
// Router input stage: flit FIFO plus head-decode FSM that holds req for a whole
// packet. Optional credit return is enabled with `define CREDIT_FLOW_EN.
// Handshake: a flit is pushed on any cycle with in_valid && in_ready; a flit is
// popped while ACTIVE on any cycle with grant && out_valid (no other handshake).
module input_port_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 grant,
  output logic [FLIT_W-1:0]    out_flit,
  output logic                 out_valid,
  output logic                 req,
  output logic [FLIT_ID_W-1:0] flit_id,
  output logic [LEN_W-1:0]     length,
  output logic                 err,
  output logic [CW-1:0]        fill,
`ifdef CREDIT_FLOW_EN
  output logic                 credit_out,
  output logic [CW-1:0]        credit_init,
`endif
  output ibuf_state_t          dbg_state
);

  ibuf_state_t          state, state_n;
  logic                 first_flit;
  logic                 full, empty;
  logic                 pop;
  logic                 bad;
  logic                 load;
  logic [FLIT_ID_W-1:0] head_id;

  flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_flit),
    .pop     (pop),
    .rd_data (out_flit),
    .full    (full),
    .empty   (empty),
    .fill    (fill)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign head_id   = out_flit[FLIT_W-1 -: FLIT_ID_W];
  assign flit_id   = out_valid ? head_id : '0;
  assign req       = (state == ACTIVE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    bad     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (out_valid) begin
          if (head_id == FLIT_HEADER) begin
            state_n = ACTIVE;
            load    = 1'b1;
          end else begin
            pop = 1'b1;
            bad = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (grant && out_valid) begin
          pop = 1'b1;
          if (head_id == FLIT_TAIL) state_n = IDLE;
          // Only the header that opened this packet is expected; any later one
          // means the previous tail went missing.
          if (head_id == FLIT_HEADER && !first_flit) begin
            load = 1'b1;
            bad  = 1'b1;
          end else if (!flit_id_legal(head_id)) begin
            bad = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      first_flit <= 1'b0;
      length     <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      err   <= bad;
      if (load) length <= out_flit[LEN_W-1:0];
      if (state == IDLE && state_n == ACTIVE) first_flit <= 1'b1;
      else if (pop)                           first_flit <= 1'b0;
    end
  end

`ifdef CREDIT_FLOW_EN
  logic rst_q;

  assign credit_out = pop;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) credit_init <= '0;
    else     credit_init <= rst_q ? CW'(DEPTH) : '0;
  end
`endif

endmodule
